// File: rtl/sequencer.sv
// -----------------------------------------------------------------------------
// sequencer
//
// Upstream step generator for the shift/add datapath controller. Accepts one
// operation request per handshake and emits a 3-bit step code Q, one code per
// clock. Q, busy and done are all registered, so there is no combinational
// path from any input to any output.
//
// Optional feature macro: SEQ_STEP_EN
//   defined   : adds input 'step'; outside IDLE the FSM advances only on
//               edges where step=1, otherwise Q, busy and the shift counter
//               hold. Acceptance from IDLE ignores step.
//   undefined : no 'step' port; the FSM advances every cycle.
//
// Parameters:
//   CNT_W   width of the shift-count field (max shift repeat 2^CNT_W-1)
//
// Ports:
//   clock   in   1      system clock, rising edge
//   reset   in   1      synchronous, active-high, dominates all inputs
//   start   in   1      request strobe, sampled only while busy=0
//   op      in   2      00 PASS, 01 ADD, 10 SUB, 11 ADDSH
//   shamt   in   CNT_W  shift repeat count (ADDSH only)
//   step    in   1      advance enable (SEQ_STEP_EN builds only)
//   Q       out  3      step code to the controller
//   busy    out  1      high while a sequence is in flight
//   done    out  1      one-cycle pulse in the first IDLE cycle after STORE
//
// States:
//   state | meaning
//   IDLE  | waiting for start, Q=110
//   FETCH | first step of every sequence, Q=000
//   EXEC  | ALU step, Q=001 ADD / 011 SUB / 010 ADDSH
//   SHIFT | shift step repeated shamt times, Q=100
//   STORE | final write-back step, Q=101
// -----------------------------------------------------------------------------
module sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] shamt,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  output logic [2:0]       Q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    SHIFT = 3'd3,
    STORE = 3'd4
  } state_t;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_ADDSH = 2'b11;

  localparam logic [2:0] Q_IDLE  = 3'b110;
  localparam logic [2:0] Q_FETCH = 3'b000;
  localparam logic [2:0] Q_ADD   = 3'b001;
  localparam logic [2:0] Q_SUB   = 3'b011;
  localparam logic [2:0] Q_ADDSH = 3'b010;
  localparam logic [2:0] Q_SHIFT = 3'b100;
  localparam logic [2:0] Q_STORE = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             advance;
  logic             load;
  logic             dec;
  logic             done_next;
  logic             busy_next;
  logic [2:0]       q_next;

`ifdef SEQ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    dec        = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          load       = 1'b1;
        end
      end
      FETCH: begin
        if (advance) begin
          state_next = (op_r == OP_PASS) ? STORE : EXEC;
        end
      end
      EXEC: begin
        // ADDSH with a zero count skips SHIFT entirely
        if (advance) begin
          state_next = ((op_r == OP_ADDSH) && (cnt != '0)) ? SHIFT : STORE;
        end
      end
      SHIFT: begin
        // leave on the cycle where the count is 1 before decrementing
        if (advance) begin
          dec = 1'b1;
          if (cnt <= CNT_ONE) begin
            state_next = STORE;
          end
        end
      end
      STORE: begin
        if (advance) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output codes are derived from the next state so that Q/busy can be
  // registered and still line up with the state they describe.
  always_comb begin
    q_next = Q_IDLE;
    case (state_next)
      IDLE:  q_next = Q_IDLE;
      FETCH: q_next = Q_FETCH;
      EXEC: begin
        case (op_r)
          OP_ADD:   q_next = Q_ADD;
          OP_SUB:   q_next = Q_SUB;
          OP_ADDSH: q_next = Q_ADDSH;
          default:  q_next = Q_ADD;
        endcase
      end
      SHIFT: q_next = Q_SHIFT;
      STORE: q_next = Q_STORE;
      default: q_next = Q_IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op_r  <= OP_PASS;
      cnt   <= '0;
      Q     <= Q_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      Q     <= q_next;
      busy  <= busy_next;
      done  <= done_next;
      if (load) begin
        op_r <= op;
        cnt  <= shamt;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sequencer.sv
module tb_sequencer;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] shamt;
  logic [2:0]       Q;
  logic             busy;
  logic             done;
`ifdef SEQ_STEP_EN
  logic             step = 1'b1;
`endif

  always #5 clock = ~clock;

  sequencer #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .shamt (shamt),
`ifdef SEQ_STEP_EN
    .step  (step),
`endif
    .Q     (Q),
    .busy  (busy),
    .done  (done)
  );

  // scoreboard entries: {busy, done, Q}
  logic [4:0] sb[$];
  logic [4:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // codes listed first-to-last as octal digits
  task automatic push_seq(input int n, input logic [29:0] codes, input bit with_done);
    for (int i = 0; i < n; i++) sb.push_back({2'b10, codes[3*(n-1-i) +: 3]});
    if (with_done) sb.push_back({2'b01, 3'b110});
  endtask

  task automatic issue(input logic [1:0] o, input logic [CNT_W-1:0] s);
    op    = o;
    shamt = s;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op    = ~o;
    shamt = '0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_drain"}, {31'd0, ok}, 32'd1);
    @(posedge clock); #1;
  endtask

  // monitor: pops an expectation whenever the DUT presents a code
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (busy === 1'b1 || done === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_output", {27'd0, busy, done, Q}, {27'd0, 2'b00, 3'b110});
          end else begin
            mon_e = sb.pop_front();
            check("seq_item", {27'd0, busy, done, Q}, {27'd0, mon_e});
          end
        end else begin
          check("idle_q", {29'd0, Q}, {29'd0, 3'b110});
        end
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    op    = 2'b01;
    shamt = '0;

    // reset held two cycles with start asserted
    @(posedge clock); #1;
    mon_en = 1'b1;
    check("reset1_q",    {29'd0, Q},    {29'd0, 3'b110});
    check("reset1_busy", {31'd0, busy}, 32'd0);
    check("reset1_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    check("reset2_q",    {29'd0, Q},    {29'd0, 3'b110});
    check("reset2_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    check("post_reset_q",    {29'd0, Q},    {29'd0, 3'b110});
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_done", {31'd0, done}, 32'd0);

    // ADD
    d0 = done_cnt;
    push_seq(3, 30'o015, 1);
    issue(2'b01, 3'd0);
    wait_drain("add");
    check("add_done_count", done_cnt - d0, 32'd1);

    // SUB with an ignored start during the 011 cycle
    d0 = done_cnt;
    push_seq(3, 30'o035, 1);
    issue(2'b10, 3'd0);
    @(posedge clock); #1;
    op    = 2'b00;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_drain("sub_ignored_start");
    check("sub_done_count", done_cnt - d0, 32'd1);

    // ADDSH shamt=3, 0 and 7
    push_seq(6, 30'o024445, 1);
    issue(2'b11, 3'd3);
    wait_drain("addsh3");
    push_seq(3, 30'o025, 1);
    issue(2'b11, 3'd0);
    wait_drain("addsh0");
    push_seq(10, 30'o0244444445, 1);
    issue(2'b11, 3'd7);
    wait_drain("addsh7");

    // PASS alone
    push_seq(2, 30'o05, 1);
    issue(2'b00, 3'd0);
    wait_drain("pass");

    // back-to-back: PASS accepted in the done cycle of an ADD
    push_seq(3, 30'o015, 1);
    push_seq(2, 30'o05, 1);
    issue(2'b01, 3'd0);
    repeat (3) begin @(posedge clock); #1; end
    check("b2b_done_cycle_done", {31'd0, done}, 32'd1);
    check("b2b_done_cycle_busy", {31'd0, busy}, 32'd0);
    issue(2'b00, 3'd0);
    check("b2b_fetch_q", {29'd0, Q}, {29'd0, 3'b000});
    wait_drain("b2b");

    // abort: reset during the second SHIFT of ADDSH shamt=5
    d0 = done_cnt;
    push_seq(4, 30'o0244, 0);
    issue(2'b11, 3'd5);
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_q",    {29'd0, Q},    {29'd0, 3'b110});
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sb_empty", sb.size(), 32'd0);
    repeat (10) begin @(posedge clock); #1; end
    check("abort_no_done", done_cnt - d0, 32'd0);

    check("final_sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
